// File: rtl/led_breathe_pwm.sv
// LED pattern generator: breathe (triangle PWM), blink and chase modes.
// A free-running PWM counter feeds a step divider; the resulting tick
// advances the pattern. LED outputs are registered one cycle after the
// counters they are decoded from.
module led_breathe_pwm #(
    parameter int unsigned N_LED    = 4,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP_DIV = 98
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    output logic [N_LED-1:0]    led,
    output logic [PWM_BITS-1:0] level,
    output logic                peak
);

    localparam int unsigned POS_W  = $clog2(N_LED);
    localparam int unsigned STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_TOP  = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0] LVL_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(N_LED - 1);
    localparam logic [N_LED-1:0]    LED_ONE   = {{(N_LED-1){1'b0}}, 1'b1};

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_BREATHE = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_CHASE   = 2'b11;

    typedef enum logic {DirUp, DirDown} dir_t;

    logic [1:0]          mode_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [POS_W-1:0]    pos;
    dir_t                dir;

    logic                clear;
    logic                pwm_wrap;
    logic                tick;
    logic [POS_W-1:0]    pos_nxt;
    logic [PWM_BITS-1:0] level_nxt;
    dir_t                dir_nxt;
    logic                peak_nxt;
    logic [N_LED-1:0]    led_nxt;

    // A mode change or disable restarts everything and suppresses the tick.
    assign clear    = !en || (mode != mode_q);
    assign pwm_wrap = (pwm_cnt == LVL_MAX);
    assign tick     = pwm_wrap && (step_cnt == STEP_LAST) && !clear;
    assign pos_nxt  = (pos == POS_LAST) ? '0 : pos + 1'b1;

    // Pattern advance on tick: brightness/position and breathe direction.
    always_comb begin
        level_nxt = level;
        dir_nxt   = dir;
        peak_nxt  = 1'b0;
        if (tick) begin
            case (mode_q)
                MODE_BREATHE: begin
                    if (dir == DirUp) begin
                        if (level != LVL_MAX) begin
                            level_nxt = level + 1'b1;
                            peak_nxt  = (level == LVL_TOP);
                        end else begin
                            level_nxt = LVL_TOP;
                            dir_nxt   = DirDown;
                        end
                    end else begin
                        if (level != '0) begin
                            level_nxt = level - 1'b1;
                        end else begin
                            level_nxt = LVL_ONE;
                            dir_nxt   = DirUp;
                        end
                    end
                end
                MODE_BLINK: level_nxt = level + 1'b1;
                MODE_CHASE: level_nxt = PWM_BITS'(pos_nxt);
                MODE_OFF:   level_nxt = level;
                default:    level_nxt = level;
            endcase
        end
    end

    // LED decode from the current counters; registered below for 1-cycle latency.
    always_comb begin
        led_nxt = '0;
        if (!clear) begin
            case (mode_q)
                MODE_BREATHE: led_nxt = {N_LED{pwm_cnt < level}};
                MODE_BLINK:   led_nxt = {N_LED{level[PWM_BITS-1]}};
                MODE_CHASE:   led_nxt = LED_ONE << pos;
                MODE_OFF:     led_nxt = '0;
                default:      led_nxt = '0;
            endcase
        end
    end

    // Counters, pattern state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            pwm_cnt  <= '0;
            step_cnt <= '0;
            pos      <= '0;
            dir      <= DirUp;
            level    <= '0;
            peak     <= 1'b0;
            led      <= '0;
        end else begin
            mode_q <= mode;
            if (clear) begin
                pwm_cnt  <= '0;
                step_cnt <= '0;
                pos      <= '0;
                dir      <= DirUp;
                level    <= '0;
                peak     <= 1'b0;
                led      <= '0;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
                if (pwm_wrap) begin
                    step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
                end
                if (tick && (mode_q == MODE_CHASE)) begin
                    pos <= pos_nxt;
                end
                dir   <= dir_nxt;
                level <= level_nxt;
                peak  <= peak_nxt;
                led   <= led_nxt;
            end
        end
    end

endmodule
